// File: rtl/probe_capture_controller.sv
`timescale 1ns/1ps
// probe_capture_controller
//
// Runs one logic-probe capture from start to finish. First it pulses a clear
// to the probe. Then it waits for a trigger pattern on the probed channels.
// After the trigger it issues exactly S sample strobes, one every
// (divider+1) clk cycles. The first strobe is the trigger sample itself.
// The host starts a capture with arm, cancels it with abort, and sees the
// current phase on the armed, capturing and done flags.
//
// Optional feature: define PROBE_EDGE_TRIGGER_EN to trigger on the first
// cycle the pattern becomes true (edge trigger) instead of whenever it is
// true (level trigger, the default).
//
// Ports:
//   clk           single clock
//   reset         synchronous reset, active-low (0 = reset)
//   arm           start a capture (honoured in IDLE or DONE)
//   abort         cancel the capture (honoured in ARMED or CAPTURE)
//   triggerMask   1 = channel takes part in the trigger compare
//   triggerValue  required level per masked channel
//   divider       sample period minus 1, in clk cycles
//   dataIn        probed channels (same bus the probe records)
//   probeReset    one-cycle clear pulse to the probe
//   probeStart    one-cycle pulse on the trigger sample
//   probeSample   one-cycle sample strobe
//   armed         high while waiting for the trigger
//   capturing     high while strobes are being issued
//   done          high once S strobes have been issued
//   sampleCount   strobes issued in the current capture
module probe_capture_controller #(
    parameter int LOG2_OF_NUMBER_OF_CHANNELS = 4,
    parameter int LOG2_OF_NUMBER_OF_SAMPLES  = 8,
    parameter int DIVIDER_WIDTH              = 16
) (
    input  logic                                         clk,
    input  logic                                         reset,
    input  logic                                         arm,
    input  logic                                         abort,
    input  logic [(1 << LOG2_OF_NUMBER_OF_CHANNELS)-1:0] triggerMask,
    input  logic [(1 << LOG2_OF_NUMBER_OF_CHANNELS)-1:0] triggerValue,
    input  logic [DIVIDER_WIDTH-1:0]                     divider,
    input  logic [(1 << LOG2_OF_NUMBER_OF_CHANNELS)-1:0] dataIn,
    output logic                                         probeReset,
    output logic                                         probeStart,
    output logic                                         probeSample,
    output logic                                         armed,
    output logic                                         capturing,
    output logic                                         done,
    output logic [LOG2_OF_NUMBER_OF_SAMPLES:0]           sampleCount
);

    localparam int              CW          = LOG2_OF_NUMBER_OF_SAMPLES + 1;
    localparam logic [CW-1:0]   FIRST_COUNT = CW'(1);
    localparam logic [CW-1:0]   FULL_COUNT  = CW'(1) << LOG2_OF_NUMBER_OF_SAMPLES;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_ARMED,
        S_CAPTURE,
        S_DONE
    } state_t;

    state_t                    state;
    state_t                    next_state;

    logic [DIVIDER_WIDTH-1:0]  period_q;
    logic [DIVIDER_WIDTH-1:0]  countdown_q;
    logic [DIVIDER_WIDTH-1:0]  period_d;
    logic [DIVIDER_WIDTH-1:0]  countdown_d;
    logic [CW-1:0]             sample_count_d;
    logic [CW-1:0]             count_inc;
    logic                      probe_reset_d;
    logic                      probe_start_d;
    logic                      probe_sample_d;
    logic                      match;
    logic                      trigger;
    logic                      strobe_due;

    assign match      = ((dataIn ^ triggerValue) & triggerMask) == '0;
    assign strobe_due = (countdown_q == '0);
    assign count_inc  = sampleCount + FIRST_COUNT;

`ifdef PROBE_EDGE_TRIGGER_EN
    // The pattern seen in the previous cycle. It is forced high on the way
    // into ARMED, so a pattern that is already present at arm time never
    // fires. The capture waits for the pattern to go away and come back.
    logic prev_match;

    always_ff @(posedge clk) begin
        if (!reset) begin
            prev_match <= 1'b1;
        end else if (state == S_CLEAR) begin
            prev_match <= 1'b1;
        end else begin
            prev_match <= match;
        end
    end

    assign trigger = match & ~prev_match;
`else
    assign trigger = match;
`endif

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: state elements take non-blocking assignments so every
        // register samples the pre-edge values, regardless of block order.
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic. abort beats both the trigger and a due strobe.
    always_comb begin
        // NOTE: default first, so no path through the case leaves next_state
        // unassigned and infers a latch.
        next_state = state;
        case (state)
            S_IDLE:    if (arm) next_state = S_CLEAR;
            S_CLEAR:   next_state = S_ARMED;
            S_ARMED: begin
                if (abort) begin
                    next_state = S_IDLE;
                end else if (trigger) begin
                    next_state = (FIRST_COUNT == FULL_COUNT) ? S_DONE : S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                if (abort) begin
                    next_state = S_IDLE;
                end else if (strobe_due && (count_inc == FULL_COUNT)) begin
                    next_state = S_DONE;
                end
            end
            S_DONE:    if (arm) next_state = S_CLEAR;
            default:   next_state = S_IDLE;
        endcase
    end

    // Output logic. It computes the values that every registered output and
    // the period/countdown pair will take after the coming edge.
    always_comb begin
        probe_start_d  = 1'b0;
        probe_sample_d = 1'b0;
        sample_count_d = sampleCount;
        period_d       = period_q;
        countdown_d    = countdown_q;
        case (state)
            S_IDLE, S_DONE: begin
                if (arm) sample_count_d = '0;
            end
            S_ARMED: begin
                // The divider is captured here only. Later changes to it
                // wait for the next trigger.
                if (!abort && trigger) begin
                    probe_start_d  = 1'b1;
                    probe_sample_d = 1'b1;
                    sample_count_d = FIRST_COUNT;
                    period_d       = divider;
                    countdown_d    = divider;
                end
            end
            S_CAPTURE: begin
                if (!abort) begin
                    if (strobe_due) begin
                        probe_sample_d = 1'b1;
                        sample_count_d = count_inc;
                        countdown_d    = period_q;
                    end else begin
                        countdown_d = countdown_q - DIVIDER_WIDTH'(1);
                    end
                end
            end
            default: ;
        endcase
        probe_reset_d = (next_state == S_CLEAR);
    end

    // Output and datapath registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            probeReset  <= 1'b0;
            probeStart  <= 1'b0;
            probeSample <= 1'b0;
            armed       <= 1'b0;
            capturing   <= 1'b0;
            done        <= 1'b0;
            sampleCount <= '0;
            period_q    <= '0;
            countdown_q <= '0;
        end else begin
            probeReset  <= probe_reset_d;
            probeStart  <= probe_start_d;
            probeSample <= probe_sample_d;
            armed       <= (next_state == S_ARMED);
            capturing   <= (next_state == S_CAPTURE);
            done        <= (next_state == S_DONE);
            sampleCount <= sample_count_d;
            period_q    <= period_d;
            countdown_q <= countdown_d;
        end
    end

endmodule

// File: tb/tb_probe_capture_controller.sv
`timescale 1ns/1ps
module tb_probe_capture_controller;

    localparam int         LCH   = 4;
    localparam int         LSM   = 8;
    localparam int         DW    = 16;
    localparam int         N     = 1 << LCH;
    localparam int         S     = 1 << LSM;
    localparam logic [8:0] FULL  = 9'd256;

    logic          clk = 1'b0;
    logic          reset;
    logic          arm;
    logic          abort;
    logic [N-1:0]  triggerMask;
    logic [N-1:0]  triggerValue;
    logic [DW-1:0] divider;
    logic [N-1:0]  dataIn;
    logic          probeReset;
    logic          probeStart;
    logic          probeSample;
    logic          armed;
    logic          capturing;
    logic          done;
    logic [LSM:0]  sampleCount;

    int unsigned cyc = 0;
    int          tests_run = 0;
    int          tests_failed = 0;

    typedef struct {
        int unsigned cyc;
        logic        start;
        int          count;
    } strobe_t;

    strobe_t exp_q[$];
    strobe_t mon_e;

    probe_capture_controller #(
        .LOG2_OF_NUMBER_OF_CHANNELS(LCH),
        .LOG2_OF_NUMBER_OF_SAMPLES (LSM),
        .DIVIDER_WIDTH             (DW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .arm         (arm),
        .abort       (abort),
        .triggerMask (triggerMask),
        .triggerValue(triggerValue),
        .divider     (divider),
        .dataIn      (dataIn),
        .probeReset  (probeReset),
        .probeStart  (probeStart),
        .probeSample (probeSample),
        .armed       (armed),
        .capturing   (capturing),
        .done        (done),
        .sampleCount (sampleCount)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    // Scoreboard consumer: every strobe must match the oldest expected one.
    always @(negedge clk) begin
        if (probeSample === 1'b1) begin
            tests_run++;
            if (exp_q.size() == 0) begin
                tests_failed++;
                $display("FAIL unexpected_strobe: cyc=%0d count=%0d, required no strobe", cyc, sampleCount);
            end else begin
                mon_e = exp_q.pop_front();
                if (cyc !== mon_e.cyc || probeStart !== mon_e.start || sampleCount !== 9'(mon_e.count)) begin
                    tests_failed++;
                    $display("FAIL strobe: got cyc=%0d start=%b count=%0d, required cyc=%0d start=%b count=%0d",
                             cyc, probeStart, sampleCount, mon_e.cyc, mon_e.start, mon_e.count);
                end
            end
        end else if (probeStart === 1'b1) begin
            tests_run++;
            tests_failed++;
            $display("FAIL start_without_sample: cyc=%0d start=1 sample=0, required start=0", cyc);
        end
        if (probeReset === 1'b1) begin
            tests_run++;
            if (probeSample !== 1'b0 || probeStart !== 1'b0) begin
                tests_failed++;
                $display("FAIL reset_overlap: cyc=%0d start=%b sample=%b, required both 0", cyc, probeStart, probeSample);
            end
        end
    end

    task automatic to_cyc(input int unsigned t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic pulse_arm(input logic with_abort, output int unsigned a);
        a     = cyc;
        arm   = 1'b1;
        abort = with_abort;
        @(negedge clk);
        arm   = 1'b0;
        abort = 1'b0;
    endtask

    task automatic push_run(input int unsigned first, input int unsigned d, input int n);
        strobe_t e;
        for (int i = 0; i < n; i++) begin
            e.cyc   = first + i * (d + 1);
            e.start = (i == 0);
            e.count = i + 1;
            exp_q.push_back(e);
        end
    endtask

    task automatic drain_check(input string name);
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL %s_missing_strobes: %0d strobes outstanding, required 0", name, exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_reset();
        int unsigned r;
        reset = 1'b0; arm = 1'b1; abort = 1'b0;
        triggerMask = 16'h0001; triggerValue = 16'h0001; dataIn = '0; divider = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tests_run++;
            if ({probeReset, probeStart, probeSample, armed, capturing, done} !== 6'b0 || sampleCount !== 9'd0) begin
                tests_failed++;
                $display("FAIL reset_hold: flags=%b count=%0d, required flags=000000 count=0",
                         {probeReset, probeStart, probeSample, armed, capturing, done}, sampleCount);
            end
        end
        r = cyc;
        reset = 1'b1;
        to_cyc(r + 1);
        arm = 1'b0;
        tests_run++;
        if (probeReset !== 1'b1 || armed !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_release_clear: probeReset=%b armed=%b, required 1 0", probeReset, armed);
        end
        to_cyc(r + 2);
        tests_run++;
        if (armed !== 1'b1 || probeReset !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_release_armed: armed=%b probeReset=%b, required 1 0", armed, probeReset);
        end
        abort = 1'b1;
        to_cyc(r + 3);
        abort = 1'b0;
        tests_run++;
        if (armed !== 1'b0 || capturing !== 1'b0 || done !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_abort_idle: armed=%b capturing=%b done=%b, required 0 0 0", armed, capturing, done);
        end
        drain_check("reset");
    endtask

    task automatic test_level_fast();
        int unsigned a, last;
        triggerMask = 16'h0001; triggerValue = 16'h0001; dataIn = '0; divider = '0;
        pulse_arm(1'b0, a);
        tests_run++;
        if (probeReset !== 1'b1 || sampleCount !== 9'd0) begin
            tests_failed++;
            $display("FAIL fast_clear: probeReset=%b count=%0d, required 1 0", probeReset, sampleCount);
        end
        to_cyc(a + 2);
        tests_run++;
        if (armed !== 1'b1 || probeReset !== 1'b0) begin
            tests_failed++;
            $display("FAIL fast_armed: armed=%b probeReset=%b, required 1 0", armed, probeReset);
        end
        to_cyc(a + 10);
        dataIn = 16'h0001;
        push_run(a + 11, 0, S);
        last = a + 11 + (S - 1);
        to_cyc(last);
        tests_run++;
        if (done !== 1'b1 || capturing !== 1'b0 || sampleCount !== FULL) begin
            tests_failed++;
            $display("FAIL fast_done: done=%b capturing=%b count=%0d, required 1 0 256", done, capturing, sampleCount);
        end
        to_cyc(last + 4);
        tests_run++;
        if (done !== 1'b1 || sampleCount !== FULL) begin
            tests_failed++;
            $display("FAIL fast_done_hold: done=%b count=%0d, required 1 256", done, sampleCount);
        end
        drain_check("fast");
    endtask

    task automatic test_divider();
        int unsigned a, first, last;
        divider = 16'd3; dataIn = '0; triggerValue = 16'h0001;
`ifdef PROBE_EDGE_TRIGGER_EN
        triggerMask = 16'h0001;
        pulse_arm(1'b0, a);
        to_cyc(a + 3);
        dataIn = 16'h0001;
        first = a + 4;
`else
        triggerMask = '0;
        pulse_arm(1'b0, a);
        first = a + 3;
`endif
        push_run(first, 3, S);
        last = first + (S - 1) * 4;
        to_cyc(first + 100);
        divider = '0;
        to_cyc(last);
        tests_run++;
        if (done !== 1'b1 || sampleCount !== FULL) begin
            tests_failed++;
            $display("FAIL div_done: done=%b count=%0d, required 1 256", done, sampleCount);
        end
        to_cyc(last + 6);
        drain_check("div");
    endtask

    task automatic test_rearm();
        int unsigned a, last;
        triggerMask = 16'h0001; triggerValue = 16'h0001; dataIn = '0; divider = 16'd2;
        pulse_arm(1'b1, a);
        tests_run++;
        if (probeReset !== 1'b1 || sampleCount !== 9'd0 || done !== 1'b0) begin
            tests_failed++;
            $display("FAIL rearm_clear: probeReset=%b count=%0d done=%b, required 1 0 0", probeReset, sampleCount, done);
        end
        to_cyc(a + 2);
        tests_run++;
        if (armed !== 1'b1 || sampleCount !== 9'd0) begin
            tests_failed++;
            $display("FAIL rearm_armed: armed=%b count=%0d, required 1 0", armed, sampleCount);
        end
        to_cyc(a + 3);
        dataIn = 16'h0001;
        push_run(a + 4, 2, S);
        last = a + 4 + (S - 1) * 3;
        to_cyc(last);
        tests_run++;
        if (done !== 1'b1 || sampleCount !== FULL) begin
            tests_failed++;
            $display("FAIL rearm_done: done=%b count=%0d, required 1 256", done, sampleCount);
        end
        to_cyc(last + 3);
        drain_check("rearm");
    endtask

`ifdef PROBE_EDGE_TRIGGER_EN
    task automatic test_edge();
        int unsigned a, last;
        triggerMask = 16'h0001; triggerValue = 16'h0001; dataIn = 16'h0001; divider = '0;
        pulse_arm(1'b0, a);
        to_cyc(a + 6);
        tests_run++;
        if (armed !== 1'b1 || capturing !== 1'b0) begin
            tests_failed++;
            $display("FAIL edge_no_fire: armed=%b capturing=%b, required 1 0", armed, capturing);
        end
        dataIn = '0;
        to_cyc(a + 7);
        dataIn = 16'h0001;
        push_run(a + 8, 0, S);
        last = a + 8 + (S - 1);
        to_cyc(last);
        tests_run++;
        if (done !== 1'b1 || sampleCount !== FULL) begin
            tests_failed++;
            $display("FAIL edge_done: done=%b count=%0d, required 1 256", done, sampleCount);
        end
        to_cyc(last + 3);
        drain_check("edge");
    endtask
`endif

    task automatic test_abort();
        int unsigned a, b;
        triggerMask = 16'h0001; triggerValue = 16'h0001; dataIn = '0; divider = 16'd1;
        pulse_arm(1'b0, a);
        to_cyc(a + 3);
        dataIn = 16'h0001;
        push_run(a + 4, 1, 20);
        to_cyc(a + 43);
        abort = 1'b1;
        to_cyc(a + 44);
        abort = 1'b0;
        tests_run++;
        if (capturing !== 1'b0 || done !== 1'b0 || armed !== 1'b0 || sampleCount !== 9'd20) begin
            tests_failed++;
            $display("FAIL abort_capture: capturing=%b done=%b armed=%b count=%0d, required 0 0 0 20",
                     capturing, done, armed, sampleCount);
        end
        to_cyc(a + 52);
        tests_run++;
        if (sampleCount !== 9'd20 || capturing !== 1'b0) begin
            tests_failed++;
            $display("FAIL abort_hold: count=%0d capturing=%b, required 20 0", sampleCount, capturing);
        end
        drain_check("abort_capture");

        dataIn = '0;
        pulse_arm(1'b0, b);
        to_cyc(b + 2);
        abort  = 1'b1;
        dataIn = 16'h0001;
        to_cyc(b + 3);
        abort  = 1'b0;
        tests_run++;
        if (armed !== 1'b0 || probeStart !== 1'b0 || capturing !== 1'b0 || sampleCount !== 9'd0) begin
            tests_failed++;
            $display("FAIL abort_armed: armed=%b start=%b capturing=%b count=%0d, required 0 0 0 0",
                     armed, probeStart, capturing, sampleCount);
        end
        to_cyc(b + 8);
        tests_run++;
        if (armed !== 1'b0 || capturing !== 1'b0) begin
            tests_failed++;
            $display("FAIL abort_armed_idle: armed=%b capturing=%b, required 0 0", armed, capturing);
        end
        dataIn = '0;
        drain_check("abort_armed");
    endtask

    task automatic test_reset_midrun();
        int unsigned a;
        triggerMask = 16'h0001; triggerValue = 16'h0001; dataIn = '0; divider = '0;
        pulse_arm(1'b0, a);
        to_cyc(a + 3);
        dataIn = 16'h0001;
        push_run(a + 4, 0, 10);
        to_cyc(a + 13);
        reset = 1'b0;
        to_cyc(a + 14);
        tests_run++;
        if ({probeReset, probeStart, probeSample, armed, capturing, done} !== 6'b0 || sampleCount !== 9'd0) begin
            tests_failed++;
            $display("FAIL reset_midrun: flags=%b count=%0d, required flags=000000 count=0",
                     {probeReset, probeStart, probeSample, armed, capturing, done}, sampleCount);
        end
        to_cyc(a + 15);
        reset  = 1'b1;
        dataIn = '0;
        to_cyc(a + 17);
        tests_run++;
        if ({probeReset, armed, capturing, done} !== 4'b0 || sampleCount !== 9'd0) begin
            tests_failed++;
            $display("FAIL reset_midrun_idle: flags=%b count=%0d, required flags=0000 count=0",
                     {probeReset, armed, capturing, done}, sampleCount);
        end
        drain_check("reset_midrun");
    endtask

    initial begin
        test_reset();
        test_level_fast();
        test_divider();
        test_rearm();
`ifdef PROBE_EDGE_TRIGGER_EN
        test_edge();
`endif
        test_abort();
        test_reset_midrun();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
